// File: rtl/rggen_response_stage_pkg.sv
// rggen_response_stage_pkg: FSM states and response status encodings shared by the response stage
package rggen_response_stage_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;
  localparam logic [1:0] STATUS_OKAY         = 2'b00;
  localparam logic [1:0] STATUS_EXOKAY       = 2'b01;
  localparam logic [1:0] STATUS_SLAVE_ERROR  = 2'b10;
  localparam logic [1:0] STATUS_DECODE_ERROR = 2'b11;
endpackage

// File: rtl/rggen_mux.sv
// rggen_mux: one-hot AND-OR mux; several select bits OR the selected entries together
module rggen_mux #(
  parameter int WIDTH   = 1,
  parameter int ENTRIES = 2
) (
  input  logic [ENTRIES-1:0]       i_select,
  input  logic [WIDTH*ENTRIES-1:0] i_data,
  output logic [WIDTH-1:0]         o_data
);
  always_comb begin
    o_data = '0;
    for (int i = 0; i < ENTRIES; i++) o_data = o_data | (i_data[WIDTH*i+:WIDTH] & {WIDTH{i_select[i]}});
  end
endmodule

// File: rtl/rggen_response_stage.sv
// rggen_response_stage: selects the completing register and holds its data/status as a valid/ready response
module rggen_response_stage
  import rggen_response_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REGISTERS      = 4,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int COUNTER_WIDTH  = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_request_valid,
  output logic                            o_request_ready,
  input  logic [REGISTERS-1:0]            i_register_active,
  input  logic [REGISTERS-1:0]            i_register_ready,
  input  logic [2*REGISTERS-1:0]          i_register_status,
  input  logic [DATA_WIDTH*REGISTERS-1:0] i_register_data,
  output logic                            o_response_valid,
  input  logic                            i_response_ready,
  output logic [1:0]                      o_response_status,
  output logic [DATA_WIDTH-1:0]           o_response_data,
  output logic                            o_busy
);
  localparam bit                     LP_TIMEOUT_EN = TIMEOUT_CYCLES != 0;
  localparam logic [COUNTER_WIDTH-1:0] LP_LAST     = COUNTER_WIDTH'(LP_TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);
  state_e                  r_state;
  logic [COUNTER_WIDTH-1:0] r_counter;
  logic [REGISTERS-1:0]    w_hit;
  logic [DATA_WIDTH-1:0]   w_mux_data;
  logic [1:0]              w_mux_status;
  logic                    w_hit_any;
  logic                    w_decode_error;
  logic                    w_complete;
  logic                    w_timeout;
  state_e                  w_next;
  assign w_hit          = i_register_active & i_register_ready;
  assign w_hit_any      = |w_hit;
  assign w_decode_error = r_state == ST_IDLE && i_request_valid && i_register_active == '0;
  assign w_complete     = r_state == ST_WAIT && i_request_valid && w_hit_any;
  assign w_timeout      = r_state == ST_WAIT && i_request_valid && !w_hit_any && LP_TIMEOUT_EN && r_counter == LP_LAST;
  rggen_mux #(.WIDTH(DATA_WIDTH), .ENTRIES(REGISTERS)) u_data_mux (
    .i_select (w_hit),
    .i_data   (i_register_data),
    .o_data   (w_mux_data)
  );
  rggen_mux #(.WIDTH(2), .ENTRIES(REGISTERS)) u_status_mux (
    .i_select (w_hit),
    .i_data   (i_register_status),
    .o_data   (w_mux_status)
  );
  // a dropped request wins over a same-cycle hit or timeout
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: w_next = !i_request_valid ? ST_IDLE : w_decode_error ? ST_RESP : ST_WAIT;
      ST_WAIT: w_next = !i_request_valid ? ST_IDLE : (w_complete || w_timeout) ? ST_RESP : ST_WAIT;
      default: w_next = i_response_ready ? ST_IDLE : ST_RESP;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= ST_IDLE;
      o_request_ready  <= 1'b0;
      o_response_valid <= 1'b0;
      o_busy           <= 1'b0;
    end else begin
      r_state          <= w_next;
      o_request_ready  <= w_decode_error || w_complete || w_timeout;
      o_response_valid <= w_next == ST_RESP;
      o_busy           <= w_next != ST_IDLE;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst || r_state != ST_WAIT) r_counter <= '0;
    else if (r_counter != '1) r_counter <= r_counter + 1'b1;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_response_status <= STATUS_OKAY;
      o_response_data   <= '0;
    end else if (w_decode_error) begin
      o_response_status <= STATUS_DECODE_ERROR;
      o_response_data   <= '0;
    end else if (w_complete) begin
      o_response_status <= w_mux_status;
      o_response_data   <= w_mux_data;
    end else if (w_timeout) begin
      o_response_status <= STATUS_SLAVE_ERROR;
      o_response_data   <= '0;
    end
  end
endmodule

// File: tb/tb_rggen_response_stage.sv
// tb_rggen_response_stage: scenario tasks with a response scoreboard; TIMEOUT_CYCLES=4 and 0 instances share stimulus
module tb_rggen_response_stage;
  typedef struct packed {logic [1:0] st; logic [31:0] d;} resp_t;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req = 1'b0;
  logic [3:0]   act = '0;
  logic [3:0]   rdy = '0;
  logic [7:0]   sts = '0;
  logic [127:0] dat = '0;
  logic         rrdy = 1'b0;
  logic         a_rr, a_v, a_b, b_rr, b_v, b_b;
  logic [1:0]   a_s, b_s;
  logic [31:0]  a_d, b_d;
  resp_t        sb[$];
  int           total = 0;
  int           passed = 0;
  always #5 clk = ~clk;
  rggen_response_stage #(.DATA_WIDTH(32), .REGISTERS(4), .TIMEOUT_CYCLES(4), .COUNTER_WIDTH(8)) dut_t (
    .i_clk(clk), .i_rst(rst), .i_request_valid(req), .o_request_ready(a_rr),
    .i_register_active(act), .i_register_ready(rdy), .i_register_status(sts), .i_register_data(dat),
    .o_response_valid(a_v), .i_response_ready(rrdy), .o_response_status(a_s), .o_response_data(a_d), .o_busy(a_b)
  );
  rggen_response_stage #(.DATA_WIDTH(32), .REGISTERS(4), .TIMEOUT_CYCLES(0), .COUNTER_WIDTH(8)) dut_n (
    .i_clk(clk), .i_rst(rst), .i_request_valid(req), .o_request_ready(b_rr),
    .i_register_active(act), .i_register_ready(rdy), .i_register_status(sts), .i_register_data(dat),
    .o_response_valid(b_v), .i_response_ready(rrdy), .o_response_status(b_s), .o_response_data(b_d), .o_busy(b_b)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic fill_random();
    dat = {$urandom, $urandom, $urandom, $urandom};
    sts = 8'b10_10_10_10;
  endtask
  task automatic test_reset();
    req = 1'b1; act = 4'b0100; rst = 1'b1;
    repeat (3) step();
    total++;
    if ({a_rr, a_v, a_s, a_d, a_b} !== '0) $display("FAIL reset_t got rr%b v%b s%b d%h b%b want all 0", a_rr, a_v, a_s, a_d, a_b); else passed++;
    total++;
    if ({b_rr, b_v, b_s, b_d, b_b} !== '0) $display("FAIL reset_n got rr%b v%b s%b d%h b%b want all 0", b_rr, b_v, b_s, b_d, b_b); else passed++;
    rst = 1'b0;
    step();
    total++;
    if (a_b !== 1'b1) $display("FAIL reset_accept got busy %b want 1", a_b); else passed++;
    req = 1'b0;
    step();
    total++;
    if (a_b !== 1'b0 || a_v !== 1'b0) $display("FAIL reset_abort got busy %b valid %b want 0 0", a_b, a_v); else passed++;
  endtask
  task automatic test_read();
    resp_t e;
    fill_random();
    dat[64+:32] = 32'hDEAD_BEEF; sts[4+:2] = 2'b00;
    req = 1'b1; act = 4'b0100; rdy = 4'b0000;
    sb.push_back({2'b00, 32'hDEAD_BEEF});
    step();
    total++;
    if (a_v !== 1'b0 || a_rr !== 1'b0) $display("FAIL read_wait got valid %b rr %b want 0 0", a_v, a_rr); else passed++;
    rdy = 4'b0100;
    step();
    total++;
    if (a_v !== 1'b1 || a_rr !== 1'b1) $display("FAIL read_valid got valid %b rr %b want 1 1", a_v, a_rr); else passed++;
    if (a_v === 1'b1) begin
      e = sb.pop_front();
      total++;
      if ({a_s, a_d} !== {e.st, e.d}) $display("FAIL read_data got %b %h want %b %h", a_s, a_d, e.st, e.d); else passed++;
    end
    req = 1'b0; rdy = 4'b0000;
    step();
    total++;
    if (a_rr !== 1'b0 || a_v !== 1'b1) $display("FAIL read_pulse got rr %b valid %b want 0 1", a_rr, a_v); else passed++;
    rrdy = 1'b1;
    step();
    rrdy = 1'b0;
    total++;
    if (a_v !== 1'b0 || a_b !== 1'b0) $display("FAIL read_handshake got valid %b busy %b want 0 0", a_v, a_b); else passed++;
  endtask
  task automatic test_decode();
    resp_t e;
    int bad = 0;
    fill_random();
    req = 1'b1; act = 4'b0000; rdy = 4'b1111;
    sb.push_back({2'b11, 32'h0});
    step();
    req = 1'b0;
    total++;
    if (a_v !== 1'b1 || a_rr !== 1'b1) $display("FAIL decode_valid got valid %b rr %b want 1 1", a_v, a_rr); else passed++;
    if (a_v === 1'b1) begin
      e = sb.pop_front();
      total++;
      if ({a_s, a_d} !== {e.st, e.d}) $display("FAIL decode_data got %b %h want %b %h", a_s, a_d, e.st, e.d); else passed++;
    end
    for (int i = 0; i < 5; i++) begin
      fill_random();
      step();
      if (a_v !== 1'b1 || a_s !== 2'b11 || a_d !== 32'h0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL decode_hold got %0d unstable cycles want 0", bad); else passed++;
    rrdy = 1'b1;
    step();
    rrdy = 1'b0;
    rdy = 4'b0000;
  endtask
  task automatic test_timeout();
    resp_t e;
    int bad = 0;
    req = 1'b1; act = 4'b0001; rdy = 4'b0000;
    sb.push_back({2'b10, 32'h0});
    step();
    repeat (3) step();
    total++;
    if (a_v !== 1'b0 || a_b !== 1'b1) $display("FAIL timeout_early got valid %b busy %b want 0 1", a_v, a_b); else passed++;
    step();
    total++;
    if (a_v !== 1'b1 || a_rr !== 1'b1) $display("FAIL timeout_valid got valid %b rr %b want 1 1", a_v, a_rr); else passed++;
    if (a_v === 1'b1) begin
      e = sb.pop_front();
      total++;
      if ({a_s, a_d} !== {e.st, e.d}) $display("FAIL timeout_data got %b %h want %b %h", a_s, a_d, e.st, e.d); else passed++;
    end
    for (int i = 0; i < 300; i++) begin
      step();
      if (b_v !== 1'b0 || b_rr !== 1'b0 || b_b !== 1'b1) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL timeout_disabled got %0d bad cycles want 0", bad); else passed++;
    total++;
    if (a_v !== 1'b1 || a_s !== 2'b10) $display("FAIL timeout_hold got valid %b status %b want 1 10", a_v, a_s); else passed++;
    req = 1'b0; rrdy = 1'b1;
    step();
    rrdy = 1'b0;
    total++;
    if (a_b !== 1'b0 || b_b !== 1'b0) $display("FAIL timeout_idle got busy %b %b want 0 0", a_b, b_b); else passed++;
  endtask
  task automatic test_abort();
    fill_random();
    req = 1'b1; act = 4'b0010; rdy = 4'b0000;
    step();
    req = 1'b0; rdy = 4'b0010;
    step();
    total++;
    if (a_v !== 1'b0 || a_rr !== 1'b0 || a_b !== 1'b0) $display("FAIL abort got valid %b rr %b busy %b want 0 0 0", a_v, a_rr, a_b); else passed++;
    step();
    total++;
    if (a_v !== 1'b0 || b_v !== 1'b0) $display("FAIL abort_after got valid %b %b want 0 0", a_v, b_v); else passed++;
    rdy = 4'b0000;
  endtask
  task automatic test_back_to_back();
    resp_t e;
    fill_random();
    dat[0+:32] = 32'h0000_0F0F; dat[32+:32] = 32'h0000_F000;
    sts[1:0] = 2'b00; sts[3:2] = 2'b01;
    req = 1'b1; act = 4'b0011; rdy = 4'b0011;
    sb.push_back({2'b01, 32'h0000_FF0F});
    sb.push_back({2'b01, 32'h0000_FF0F});
    repeat (2) step();
    total++;
    if (a_v !== 1'b1) $display("FAIL b2b_first got valid %b want 1", a_v); else passed++;
    if (a_v === 1'b1) begin
      e = sb.pop_front();
      total++;
      if ({a_s, a_d} !== {e.st, e.d}) $display("FAIL b2b_multihit got %b %h want %b %h", a_s, a_d, e.st, e.d); else passed++;
    end
    rrdy = 1'b1;
    step();
    rrdy = 1'b0;
    total++;
    if (a_v !== 1'b0 || a_b !== 1'b0) $display("FAIL b2b_bubble got valid %b busy %b want 0 0", a_v, a_b); else passed++;
    step();
    total++;
    if (a_b !== 1'b1 || a_v !== 1'b0) $display("FAIL b2b_restart got busy %b valid %b want 1 0", a_b, a_v); else passed++;
    step();
    total++;
    if (a_v !== 1'b1 || a_rr !== 1'b1) $display("FAIL b2b_second got valid %b rr %b want 1 1", a_v, a_rr); else passed++;
    if (a_v === 1'b1) begin
      e = sb.pop_front();
      total++;
      if ({a_s, a_d} !== {e.st, e.d}) $display("FAIL b2b_second_data got %b %h want %b %h", a_s, a_d, e.st, e.d); else passed++;
    end
    req = 1'b0; rdy = 4'b0000; rrdy = 1'b1;
    step();
    rrdy = 1'b0;
  endtask
  initial begin
    test_reset();
    test_read();
    test_decode();
    test_timeout();
    test_abort();
    test_back_to_back();
    total++;
    if (sb.size() != 0) $display("FAIL scoreboard_left got %0d entries want 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
